// File: rtl/aes_pipe_sched.sv
// Two-requester scheduler feeding a fixed-latency delay train, with valid/tag tracking,
// credit-limited output FIFO. Define AES_SCHED_STRICT_PRIO_EN for fixed priority (req0 wins).
module aes_pipe_sched #(
  parameter int LATENCY     = 3,
  parameter int WINDOW_SIZE = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req0_valid,
  input  logic                           req1_valid,
  input  logic [WINDOW_SIZE-1:0]         req0_data,
  input  logic [WINDOW_SIZE-1:0]         req1_data,
  output logic                           req0_ready,
  output logic                           req1_ready,
  output logic [WINDOW_SIZE-1:0]         pipe_in_data,
  input  logic [WINDOW_SIZE-1:0]         pipe_out_data,
  output logic                           out_valid,
  output logic [WINDOW_SIZE-1:0]         out_data,
  output logic                           out_tag,
  input  logic                           out_ready,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [LATENCY-1:0]     vld;
  logic [LATENCY-1:0]     tag;
  logic [WINDOW_SIZE-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  mem_tag;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [31:0]            occ;
  logic                   credit_ok;
  logic                   grant0;
  logic                   grant1;
  logic                   fire0;
  logic                   fire1;
  logic                   issue;
  logic                   retire;
  logic                   pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit uses registered counts only, so a pop frees a slot one cycle later
  // and out_ready never reaches the request side combinationally.
  assign occ       = 32'(fifo_count) + 32'(inflight);
  assign credit_ok = !reset && (occ < 32'(FIFO_DEPTH));

`ifdef AES_SCHED_STRICT_PRIO_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`else
  logic last_grant;

  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_grant <= 1'b1;
    else if (issue) last_grant <= fire1;
  end
`endif

  assign req0_ready = credit_ok & grant0;
  assign req1_ready = credit_ok & grant1;
  assign fire0      = req0_ready & req0_valid;
  assign fire1      = req1_ready & req1_valid;
  assign issue      = fire0 | fire1;

  always_comb begin
    pipe_in_data = '0;
    if (fire0)      pipe_in_data = req0_data;
    else if (fire1) pipe_in_data = req1_data;
  end

  assign retire    = vld[LATENCY-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_tag   = out_valid & mem_tag[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      tag <= '0;
    end else begin
      vld[0] <= issue;
      tag[0] <= fire1;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  // Storage is left unreset; out_data/out_tag are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (retire) begin
      mem[wr_ptr]     <= pipe_out_data;
      mem_tag[wr_ptr] <= tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (retire) wr_ptr <= ptr_next(wr_ptr);
      if (pop)    rd_ptr <= ptr_next(rd_ptr);
      case ({retire, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({issue, retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Scoreboard bench for aes_pipe_sched: a behavioural delay train plus a queue of issued words
// predicting ready, pipe_in_data, inflight, out_valid and output order from issue timestamps.
module tb_aes_pipe_sched;

  localparam int LAT   = 3;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int IW    = $clog2(LAT + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic [W-1:0] pipe_in_data, pipe_out_data;
  logic         out_valid, out_tag, out_ready;
  logic [W-1:0] out_data;
  logic [IW-1:0] inflight;

  aes_pipe_sched #(.LATENCY(LAT), .WINDOW_SIZE(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .pipe_in_data(pipe_in_data), .pipe_out_data(pipe_out_data),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // External "round" datapath: LAT registers with a visible transform at the output.
  function automatic logic [W-1:0] xf(input logic [W-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h3C5A;
  endfunction

  logic [W-1:0] train [LAT];
  always @(posedge clk) begin
    train[0] <= pipe_in_data;
    for (int i = 1; i < LAT; i++) train[i] <= train[i-1];
  end
  assign pipe_out_data = xf(train[LAT-1]);

  typedef struct {
    logic [W-1:0] data;
    logic         tag;
    int           stamp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic model_last = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, where inputs and combinational outputs are stable.
  always @(negedge clk) begin
    int           occ, n;
    logic         pick0, e0, e1, ev;
    logic [W-1:0] exp_pin;
    exp_t         h;
    cyc++;
    if (reset) begin
      chk("rst_ready",    32'({req0_ready, req1_ready}), 32'd0);
      chk("rst_pipe_in",  32'(pipe_in_data), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_tag",  32'(out_tag), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      q.delete();
      model_last = 1'b1;
    end else begin
      occ = q.size();
`ifdef AES_SCHED_STRICT_PRIO_EN
      pick0 = 1'b1;
`else
      pick0 = model_last;
`endif
      e0 = (occ < DEPTH) && req0_valid && (!req1_valid || pick0);
      e1 = (occ < DEPTH) && req1_valid && (!req0_valid || !pick0);
      exp_pin = e0 ? req0_data : (e1 ? req1_data : '0);
      chk("ready", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
      chk("pipe_in_data", 32'(pipe_in_data), 32'(exp_pin));

      n = 0;
      foreach (q[i]) if ((cyc - q[i].stamp) >= 1 && (cyc - q[i].stamp) <= LAT) n++;
      chk("inflight", 32'(inflight), 32'(n));

      ev = (q.size() > 0) && (cyc >= q[0].stamp + LAT + 1);
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        h = q[0];
        chk("out_data", 32'(out_data), 32'(h.data));
        chk("out_tag", 32'(out_tag), 32'(h.tag));
        if (out_ready) void'(q.pop_front());
      end

      if (e0 || e1) begin
        q.push_back('{data: xf(exp_pin), tag: e1, stamp: cyc});
        model_last = e1;
      end
      if (q.size() > DEPTH) begin
        errors++;
        checks++;
        $display("FAIL occ_bound cyc=%0d actual=%0d limit=%0d", cyc, q.size(), DEPTH);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; out_ready = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);

    // single issue
    req0_valid = 1'b1; req0_data = 16'hA5A5;
    step(1);
    req0_valid = 1'b0;
    step(8);

    // contention
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req0_data = W'($urandom); req1_data = W'($urandom);
      step(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(6);

    // backpressure, then release while still streaming
    out_ready = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_data = W'($urandom);
      step(1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_data = W'($urandom);
      step(1);
    end
    req0_valid = 1'b0;
    step(8);

    // random traffic with random backpressure
    for (int i = 0; i < 120; i++) begin
      req0_valid = ($urandom_range(2) != 0);
      req1_valid = ($urandom_range(2) != 0);
      req0_data  = W'($urandom);
      req1_data  = W'($urandom);
      out_ready  = ($urandom_range(3) != 0);
      step(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    step(12);

    // reset with two words in flight and one buffered
    out_ready = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_data = W'($urandom);
      step(1);
    end
    req0_valid = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2 * LAT + 2);
    out_ready = 1'b1;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
